// File: rtl/data_break_ctrl_if.sv
// Device/memory bus bundle for the data-break controller.
// slave = controller side, master = device/memory/CPU side.
interface data_break_ctrl_if #(
    parameter int NCH = 4
);
    logic [NCH-1:0]    req;
    logic [NCH-1:0]    three_cycle;
    logic [NCH-1:0]    to_mem;
    logic [NCH*12-1:0] dev_addr;
    logic [NCH*3-1:0]  dev_field;
    logic [NCH*12-1:0] dev_wdata;
    logic              db_gnt;
    logic [11:0]       mem_rdata;
    logic              data_break;
    logic [14:0]       mem_addr;
    logic [11:0]       mem_wdata;
    logic              mem_we;
    logic [11:0]       dev_rdata;
    logic [NCH-1:0]    grant;
    logic [NCH-1:0]    ch_done;
    logic              wc_ovf;

    modport slave (
        input  req, three_cycle, to_mem,
        input  dev_addr, dev_field, dev_wdata,
        input  db_gnt, mem_rdata,
        output data_break, mem_addr, mem_wdata,
        output mem_we, dev_rdata, grant,
        output ch_done, wc_ovf
    );

    modport master (
        output req, three_cycle, to_mem,
        output dev_addr, dev_field, dev_wdata,
        output db_gnt, mem_rdata,
        input  data_break, mem_addr, mem_wdata,
        input  mem_we, dev_rdata, grant,
        input  ch_done, wc_ovf
    );
endinterface

// File: rtl/data_break_ctrl.sv
// PDP-8e multi-channel data-break controller (single/three-cycle).
// Define DB_ROUND_ROBIN_EN for round-robin arbitration (default fixed).
module data_break_ctrl #(
    parameter int          NCH     = 4,
    parameter logic [11:0] WC_BASE = 12'o7750
) (
    input logic        clk,
    input logic        reset,
    data_break_ctrl_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE, ARB, WAIT,
        WC_RD, WC_RW, WC_WR,
        CA_RD, CA_RW, CA_WR,
        XF_RD, XF_RW, XF_WR,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [2:0]     ch;
    logic [NCH-1:0] gnt;
    logic           mode, dir, ovf, db_r;
    logic [11:0]    addr, data, wc, ca, rdata;
    logic [2:0]     field;

    logic           win_ok, win_tc, win_dir;
    logic [2:0]     win;
    logic [NCH-1:0] win_oh;
    logic [11:0]    win_addr, win_data;
    logic [2:0]     win_field;

    logic [11:0]    wc_addr, ca_addr;
    logic [14:0]    xf_addr;

`ifdef DB_ROUND_ROBIN_EN
    logic [2:0] ptr;
`endif

    // Pick the winning requester and gather its channel setup.
    always_comb begin
        win_ok    = 1'b0;
        win       = '0;
        win_oh    = '0;
        win_tc    = 1'b0;
        win_dir   = 1'b0;
        win_addr  = '0;
        win_field = '0;
        win_data  = '0;
`ifdef DB_ROUND_ROBIN_EN
        for (int k = 1; k <= NCH; k++) begin
            int idx;
            idx = (int'(ptr) + k) % NCH;
            if (!win_ok && bus.req[idx]) begin
                win_ok      = 1'b1;
                win         = 3'(idx);
                win_oh      = '0;
                win_oh[idx] = 1'b1;
                win_tc      = bus.three_cycle[idx];
                win_dir     = bus.to_mem[idx];
                win_addr    = bus.dev_addr[idx*12 +: 12];
                win_field   = bus.dev_field[idx*3 +: 3];
                win_data    = bus.dev_wdata[idx*12 +: 12];
            end
        end
`else
        for (int i = NCH - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                win_ok    = 1'b1;
                win       = 3'(i);
                win_oh    = '0;
                win_oh[i] = 1'b1;
                win_tc    = bus.three_cycle[i];
                win_dir   = bus.to_mem[i];
                win_addr  = bus.dev_addr[i*12 +: 12];
                win_field = bus.dev_field[i*3 +: 3];
                win_data  = bus.dev_wdata[i*12 +: 12];
            end
        end
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic; db_gnt low in IDLE gates each new break.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (|bus.req && !bus.db_gnt) state_nx = ARB;
            ARB:   state_nx = win_ok ? WAIT : IDLE;
            WAIT: begin
                if (bus.db_gnt) begin
                    if (mode)     state_nx = WC_RD;
                    else if (dir) state_nx = XF_WR;
                    else          state_nx = XF_RD;
                end
            end
            WC_RD: state_nx = WC_RW;
            WC_RW: state_nx = WC_WR;
            WC_WR: state_nx = CA_RD;
            CA_RD: state_nx = CA_RW;
            CA_RW: state_nx = CA_WR;
            CA_WR: state_nx = dir ? XF_WR : XF_RD;
            XF_RD: state_nx = XF_RW;
            XF_RW: state_nx = DONE;
            XF_WR: state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Channel context, WC/CA increments and read data capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ch    <= '0;
            gnt   <= '0;
            mode  <= 1'b0;
            dir   <= 1'b0;
            ovf   <= 1'b0;
            db_r  <= 1'b0;
            addr  <= '0;
            data  <= '0;
            field <= '0;
            wc    <= '0;
            ca    <= '0;
            rdata <= '0;
`ifdef DB_ROUND_ROBIN_EN
            ptr   <= 3'(NCH - 1);
`endif
        end else begin
            unique case (state)
                ARB: begin
                    if (win_ok) begin
                        ch    <= win;
                        gnt   <= win_oh;
                        mode  <= win_tc;
                        dir   <= win_dir;
                        addr  <= win_addr;
                        field <= win_field;
                        data  <= win_data;
                        ovf   <= 1'b0;
                        db_r  <= 1'b1;
`ifdef DB_ROUND_ROBIN_EN
                        ptr   <= win;
`endif
                    end
                end
                WC_RW: wc <= bus.mem_rdata + 12'd1;
                WC_WR: ovf <= (wc == 12'd0);
                CA_RW: ca <= bus.mem_rdata + 12'd1;
                XF_RW: rdata <= bus.mem_rdata;
                DONE: begin
                    db_r <= 1'b0;
                    gnt  <= '0;
                end
                default: ;
            endcase
        end
    end

    assign wc_addr = WC_BASE + {8'd0, ch, 1'b0};
    assign ca_addr = wc_addr + 12'd1;
    assign xf_addr = {field, mode ? ca : addr};

    // Memory port and completion outputs decoded from state.
    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_we    = 1'b0;
        bus.ch_done   = '0;
        bus.wc_ovf    = 1'b0;
        unique case (state)
            WC_RD, WC_RW: bus.mem_addr = {3'b000, wc_addr};
            WC_WR: begin
                bus.mem_addr  = {3'b000, wc_addr};
                bus.mem_wdata = wc;
                bus.mem_we    = 1'b1;
            end
            CA_RD, CA_RW: bus.mem_addr = {3'b000, ca_addr};
            CA_WR: begin
                bus.mem_addr  = {3'b000, ca_addr};
                bus.mem_wdata = ca;
                bus.mem_we    = 1'b1;
            end
            XF_RD, XF_RW: bus.mem_addr = xf_addr;
            XF_WR: begin
                bus.mem_addr  = xf_addr;
                bus.mem_wdata = data;
                bus.mem_we    = 1'b1;
            end
            DONE: begin
                bus.ch_done = gnt;
                bus.wc_ovf  = mode & ovf;
            end
            default: ;
        endcase
    end

    assign bus.data_break = db_r;
    assign bus.grant      = gnt;
    assign bus.dev_rdata  = rdata;

endmodule
